// File: rtl/hermes_inj_port_arbiter_if.sv
// Handshake bundle between the injector sources, the arbiter and one Hermes
// boundary port. The arbiter side uses the master modport.
//
// Handshake rule for every path in this bundle: a flit moves in a cycle where
// its valid (rx/tx) and the receiver's credit are both high. Valid must not
// depend on credit. No flit is stored inside the arbiter.
interface hermes_inj_port_arbiter_if #(
  parameter int N_SRC     = 2,
  parameter int FLIT_SIZE = 32
);
  // Forward path: sources -> PE port
  logic [N_SRC-1:0]                src_rx_i;
  logic [N_SRC-1:0]                src_credit_o;
  logic [N_SRC-1:0][FLIT_SIZE-1:0] src_data_i;
  logic                            noc_tx_o;
  logic                            noc_credit_i;
  logic [FLIT_SIZE-1:0]            noc_data_o;
  // Return path: PE port -> sources
  logic [N_SRC-1:0]                src_tx_o;
  logic [N_SRC-1:0]                src_credit_i;
  logic [N_SRC-1:0][FLIT_SIZE-1:0] src_data_o;
  logic                            noc_rx_i;
  logic                            noc_credit_o;
  logic [FLIT_SIZE-1:0]            noc_data_i;

  modport master (
    input  src_rx_i, src_data_i, src_credit_i, noc_credit_i, noc_rx_i, noc_data_i,
    output src_credit_o, src_tx_o, src_data_o, noc_tx_o, noc_data_o, noc_credit_o
  );

  modport slave (
    output src_rx_i, src_data_i, src_credit_i, noc_credit_i, noc_rx_i, noc_data_i,
    input  src_credit_o, src_tx_o, src_data_o, noc_tx_o, noc_data_o, noc_credit_o
  );
endinterface

// File: rtl/hermes_inj_port_arbiter.sv
// Shares one Hermes PE port between N_SRC injectors. Forward path is a
// packet-granular round-robin arbiter; return path steers each packet to the
// source whose address matches the header, draining unmatched packets.
module hermes_inj_port_arbiter #(
  parameter int N_SRC     = 2,
  parameter int FLIT_SIZE = 32,
  parameter int SIZE_W    = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [N_SRC-1:0]       src_en_i,
  input  logic [N_SRC-1:0][15:0] src_addr_i,
  hermes_inj_port_arbiter_if.master bus,
  output logic                   drop_o,
  output logic [N_SRC-1:0]       grant_o,
  output logic [1:0]             fwd_state_o,
  output logic [1:0]             ret_state_o
);
  localparam int IDX_W = $clog2(N_SRC);

  localparam logic [1:0] F_IDLE = 2'd0;
  localparam logic [1:0] F_HDR  = 2'd1;
  localparam logic [1:0] F_SIZE = 2'd2;
  localparam logic [1:0] F_PAY  = 2'd3;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_SIZE = 2'd1;
  localparam logic [1:0] R_PAY  = 2'd2;

  // Source index arithmetic modulo N_SRC (v is at most 2*N_SRC-2).
  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    if (v >= N_SRC) return IDX_W'(v - N_SRC);
    else            return IDX_W'(v);
  endfunction

  logic [1:0]        fstate_q, fstate_d;
  logic [IDX_W-1:0]  gidx_q, gidx_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [SIZE_W-1:0] fcnt_q, fcnt_d;
  logic              cand_found;
  logic [IDX_W-1:0]  cand_idx;
  logic              fwd_xfer;
  logic              noc_tx;
  logic [FLIT_SIZE-1:0] noc_data;
  logic [N_SRC-1:0]  src_credit;
  logic [N_SRC-1:0]  grant;

  // Forward path: round-robin pick, pass-through of the owner, size countdown.
  always_comb begin
    fstate_d   = fstate_q;
    gidx_d     = gidx_q;
    ptr_d      = ptr_q;
    fcnt_d     = fcnt_q;
    cand_found = 1'b0;
    cand_idx   = '0;
    noc_tx     = 1'b0;
    noc_data   = '0;
    src_credit = '0;
    grant      = '0;
    // Descending scan so the smallest offset from the pointer wins.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (bus.src_rx_i[wrap_idx(int'(ptr_q) + i)] && src_en_i[wrap_idx(int'(ptr_q) + i)]) begin
        cand_found = 1'b1;
        cand_idx   = wrap_idx(int'(ptr_q) + i);
      end
    end
    fwd_xfer = (fstate_q != F_IDLE) && bus.src_rx_i[gidx_q] && bus.noc_credit_i;
    if (fstate_q != F_IDLE) begin
      noc_tx             = bus.src_rx_i[gidx_q];
      noc_data           = bus.src_data_i[gidx_q];
      src_credit[gidx_q] = bus.noc_credit_i;
      grant[gidx_q]      = 1'b1;
    end
    case (fstate_q)
      F_IDLE: begin
        if (cand_found) begin
          gidx_d   = cand_idx;
          fstate_d = F_HDR;
        end
      end
      F_HDR: begin
        if (fwd_xfer) fstate_d = F_SIZE;
      end
      F_SIZE: begin
        if (fwd_xfer) begin
          fcnt_d = bus.src_data_i[gidx_q][SIZE_W-1:0];
          if (bus.src_data_i[gidx_q][SIZE_W-1:0] == '0) begin
            fstate_d = F_IDLE;
            ptr_d    = wrap_idx(int'(gidx_q) + 1);
          end else begin
            fstate_d = F_PAY;
          end
        end
      end
      default: begin
        if (fwd_xfer) begin
          fcnt_d = fcnt_q - SIZE_W'(1);
          if (fcnt_q == SIZE_W'(1)) begin
            fstate_d = F_IDLE;
            ptr_d    = wrap_idx(int'(gidx_q) + 1);
          end
        end
      end
    endcase
  end

  // Forward path state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fstate_q <= F_IDLE;
      gidx_q   <= '0;
      ptr_q    <= '0;
      fcnt_q   <= '0;
    end else begin
      fstate_q <= fstate_d;
      gidx_q   <= gidx_d;
      ptr_q    <= ptr_d;
      fcnt_q   <= fcnt_d;
    end
  end

  logic [1:0]        rstate_q, rstate_d;
  logic [IDX_W-1:0]  tgt_q, tgt_d;
  logic              drop_q, drop_d;
  logic [SIZE_W-1:0] rcnt_q, rcnt_d;
  logic              match_found;
  logic [IDX_W-1:0]  match_idx;
  logic [IDX_W-1:0]  tcur;
  logic              dcur;
  logic              ret_xfer;
  logic              noc_credit;
  logic [N_SRC-1:0]  src_tx;
  logic              drop_pulse;

  // Return path: header address match, then steer or drain until size is spent.
  // Outputs are forced low while reset is held so the port stays quiet.
  always_comb begin
    rstate_d    = rstate_q;
    tgt_d       = tgt_q;
    drop_d      = drop_q;
    rcnt_d      = rcnt_q;
    match_found = 1'b0;
    match_idx   = '0;
    src_tx      = '0;
    drop_pulse  = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (bus.noc_data_i[15:0] == src_addr_i[i]) begin
        match_found = 1'b1;
        match_idx   = IDX_W'(i);
      end
    end
    tcur        = (rstate_q == R_IDLE) ? match_idx : tgt_q;
    dcur        = (rstate_q == R_IDLE) ? !match_found : drop_q;
    noc_credit  = rst_ni && (dcur || bus.src_credit_i[tcur]);
    src_tx[tcur] = rst_ni && bus.noc_rx_i && !dcur;
    ret_xfer    = bus.noc_rx_i && noc_credit;
    case (rstate_q)
      R_IDLE: begin
        if (ret_xfer) begin
          tgt_d    = tcur;
          drop_d   = dcur;
          rstate_d = R_SIZE;
        end
      end
      R_SIZE: begin
        if (ret_xfer) begin
          rcnt_d = bus.noc_data_i[SIZE_W-1:0];
          if (bus.noc_data_i[SIZE_W-1:0] == '0) begin
            rstate_d   = R_IDLE;
            drop_pulse = drop_q;
          end else begin
            rstate_d = R_PAY;
          end
        end
      end
      default: begin
        if (ret_xfer) begin
          rcnt_d = rcnt_q - SIZE_W'(1);
          if (rcnt_q == SIZE_W'(1)) begin
            rstate_d   = R_IDLE;
            drop_pulse = drop_q;
          end
        end
      end
    endcase
  end

  // Return path state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rstate_q <= R_IDLE;
      tgt_q    <= '0;
      drop_q   <= 1'b0;
      rcnt_q   <= '0;
    end else begin
      rstate_q <= rstate_d;
      tgt_q    <= tgt_d;
      drop_q   <= drop_d;
      rcnt_q   <= rcnt_d;
    end
  end

  assign bus.noc_tx_o     = noc_tx;
  assign bus.noc_data_o   = noc_data;
  assign bus.src_credit_o = src_credit;
  assign bus.src_tx_o     = src_tx;
  assign bus.noc_credit_o = noc_credit;
  assign bus.src_data_o   = rst_ni ? {N_SRC{bus.noc_data_i}} : '0;
  assign grant_o          = grant;
  assign drop_o           = drop_pulse;
  assign fwd_state_o      = fstate_q;
  assign ret_state_o      = rstate_q;
endmodule
